// File: rtl/alu_types.sv
// Shared types for the ALU and the execute stage.
//   alu_control_t : 4-bit ALU operation code; codes 0, 4, 9, 10, 11 and 14 are undefined.
//   exec_state_t  : execute-stage FSM states.
//   is_legal_op() : 1 when the code is a defined alu_control_t operation.
package alu_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SLL  = 4'd12,
        ALU_SRL  = 4'd13,
        ALU_SRA  = 4'd15
    } alu_control_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_DONE
    } exec_state_t;

    function automatic logic is_legal_op(alu_control_t op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU.
//   i_a, i_b   : operands
//   i_op       : operation (alu_control_t); undefined codes give a zero result
//   o_result   : result, mod 2^N
//   o_overflow : signed overflow of ADD/SUB, 0 for every other operation
//   o_zero     : result is zero
//   o_equal    : operands are equal
module alu
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  alu_control_t i_op,
    output logic [N-1:0] o_result,
    output logic         o_overflow,
    output logic         o_zero,
    output logic         o_equal
);

    localparam int unsigned SW = $clog2(N);

    logic [N-1:0]  w_sum;
    logic [N-1:0]  w_diff;
    logic [SW-1:0] w_shamt;

    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_shamt = i_b[SW-1:0];

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result   = w_sum;
                // Like-signed operands producing an opposite-signed sum
                o_overflow = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            ALU_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
            end
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLT:  o_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(N-1){1'b0}}, (i_a < i_b)};
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            default:  o_result = '0;
        endcase
    end

    assign o_zero  = (o_result == '0);
    assign o_equal = (i_a == i_b);

endmodule

// File: rtl/register_file.sv
// 32-entry register file, x0 hardwired to zero.
//   clk, rst          : clock, asynchronous active-high clear of every entry
//   i_raddr_a/b       : combinational read ports A and B -> o_rdata_a/b
//   i_dbg_addr        : combinational debug read port -> o_dbg_data
//   i_we, i_waddr,
//   i_wdata           : synchronous write port; writes to x0 are dropped
module register_file #(
    parameter int unsigned N       = 32,
    parameter int unsigned Entries = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(Entries)-1:0] i_raddr_a,
    output logic [N-1:0]               o_rdata_a,
    input  logic [$clog2(Entries)-1:0] i_raddr_b,
    output logic [N-1:0]               o_rdata_b,
    input  logic [$clog2(Entries)-1:0] i_dbg_addr,
    output logic [N-1:0]               o_dbg_data,
    input  logic                       i_we,
    input  logic [$clog2(Entries)-1:0] i_waddr,
    input  logic [N-1:0]               i_wdata
);

    logic [N-1:0] r_mem [Entries];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: accept -> read operands -> execute -> hold result until taken.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : instruction handshake (ready only in S_IDLE)
//   in_op, in_rs1, in_rs2,
//   in_rd, in_imm, in_use_imm: decoded instruction, sampled on the accept edge
//   out_valid/out_ready      : result handshake; writeback to rd on the completing edge
//   out_rd, out_result,
//   out_overflow, out_zero,
//   out_equal, out_illegal   : registered result, flags and undefined-op indication
//   dbg_addr/dbg_data        : combinational register-file peek (x0 reads 0)
module exec_unit
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  alu_control_t in_op,
    input  logic [4:0]   in_rs1,
    input  logic [4:0]   in_rs2,
    input  logic [4:0]   in_rd,
    input  logic [N-1:0] in_imm,
    input  logic         in_use_imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   out_rd,
    output logic [N-1:0] out_result,
    output logic         out_overflow,
    output logic         out_zero,
    output logic         out_equal,
    output logic         out_illegal,
    input  logic [4:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    exec_state_t  r_state, w_next;
    alu_control_t r_op;
    logic [4:0]   r_rs1, r_rs2, r_rd;
    logic [N-1:0] r_imm, r_op_a, r_op_b, r_result;
    logic         r_use_imm, r_overflow, r_zero, r_equal, r_illegal;

    logic [N-1:0] w_rdata_a, w_rdata_b, w_alu_result;
    logic         w_alu_overflow, w_alu_zero, w_alu_equal, w_we;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= ALU_ADD;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_use_imm  <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_equal    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op      <= in_op;
                        r_rs1     <= in_rs1;
                        r_rs2     <= in_rs2;
                        r_rd      <= in_rd;
                        r_imm     <= in_imm;
                        r_use_imm <= in_use_imm;
                    end
                end
                S_READ: begin
                    r_op_a <= w_rdata_a;
                    r_op_b <= r_use_imm ? r_imm : w_rdata_b;
                end
                S_EXEC: begin
                    r_result   <= w_alu_result;
                    r_overflow <= w_alu_overflow;
                    r_zero     <= w_alu_zero;
                    r_equal    <= w_alu_equal;
                    r_illegal  <= !is_legal_op(r_op);
                end
                default: ;
            endcase
        end
    end

    // Writeback only on the cycle the consumer takes the result
    assign w_we = (r_state == S_DONE) && out_ready && (r_rd != '0) && !r_illegal;

    register_file #(
        .N       (N),
        .Entries (32)
    ) u_register_file (
        .clk        (clk),
        .rst        (rst),
        .i_raddr_a  (r_rs1),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (r_rs2),
        .o_rdata_b  (w_rdata_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (r_result)
    );

    alu #(
        .N (N)
    ) u_alu (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .i_op       (r_op),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_overflow),
        .o_zero     (w_alu_zero),
        .o_equal    (w_alu_equal)
    );

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign out_rd       = r_rd;
    assign out_result   = r_result;
    assign out_overflow = r_overflow;
    assign out_zero     = r_zero;
    assign out_equal    = r_equal;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed instructions against an architectural model
// (register array plus arithmetic ALU semantics), with literal pins on key results.
module tb_exec_unit;
    import alu_types::*;

    logic         clk, rst;
    logic         in_valid, in_ready, in_use_imm;
    alu_control_t in_op;
    logic [4:0]   in_rs1, in_rs2, in_rd;
    logic [31:0]  in_imm;
    logic         out_valid, out_ready;
    logic [4:0]   out_rd;
    logic [31:0]  out_result;
    logic         out_overflow, out_zero, out_equal, out_illegal;
    logic [4:0]   dbg_addr;
    logic [31:0]  dbg_data;

    exec_unit #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_use_imm   (in_use_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_equal    (out_equal),
        .out_illegal  (out_illegal),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model state and the expectation for the instruction in flight
    logic [31:0] mregs [32];
    logic        armed;
    logic [31:0] exp_result;
    logic [4:0]  exp_rd;
    logic        exp_ovf, exp_zero, exp_eq, exp_ill;
    // Values sampled from the DUT when the result first appears
    logic [31:0] last_result;
    logic        last_ovf, last_zero, last_eq, last_ill;

    localparam longint MaxS = 64'sd2147483647;
    localparam longint MinS = -64'sd2147483648;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic ovf, output logic ill);
        longint sa, sb, s;
        logic [4:0] sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = b[4:0];
        res = 32'h0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            4'd1: begin s = sa + sb; res = a + b; ovf = (s > MaxS) || (s < MinS); end
            4'd2: begin s = sa - sb; res = a - b; ovf = (s > MaxS) || (s < MinS); end
            4'd3:  res = a & b;
            4'd5:  res = a | b;
            4'd6:  res = a ^ b;
            4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  res = (a < b) ? 32'd1 : 32'd0;
            4'd12: res = a << sh;
            4'd13: res = a >> sh;
            4'd15: res = 32'(sa >>> sh);
            default: ill = 1'b1;
        endcase
    endfunction

    // Single compare process: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_valid_exclusive", {31'b0, in_ready && out_valid}, 32'd0);
            if (out_valid && armed) begin
                chk("out_result",   out_result,             exp_result);
                chk("out_rd",       {27'b0, out_rd},        {27'b0, exp_rd});
                chk("out_overflow", {31'b0, out_overflow},  {31'b0, exp_ovf});
                chk("out_zero",     {31'b0, out_zero},      {31'b0, exp_zero});
                chk("out_equal",    {31'b0, out_equal},     {31'b0, exp_eq});
                chk("out_illegal",  {31'b0, out_illegal},   {31'b0, exp_ill});
            end
        end
    end

    task automatic dbg_read(input logic [4:0] addr, output logic [31:0] d);
        dbg_addr = addr;
        #1;
        d = dbg_data;
    endtask

    task automatic issue(input alu_control_t op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm,
                         input int hold);
        logic [31:0] a, b, d;
        int          n;
        a = mregs[rs1];
        b = use_imm ? imm : mregs[rs2];
        model_alu(op, a, b, exp_result, exp_ovf, exp_ill);
        exp_zero = (exp_result == 32'h0);
        exp_eq   = (a == b);
        exp_rd   = rd;

        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_use_imm = use_imm;
        armed      = 1'b1;
        @(posedge clk);
        #1;
        // Garbage after the accept edge must be ignored
        in_valid   = 1'b0;
        in_op      = ALU_SUB;
        in_rd      = ~rd;
        in_rs1     = ~rs1;
        in_rs2     = ~rs2;
        in_imm     = ~imm;
        in_use_imm = ~use_imm;

        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("out_valid_latency_c%0d", c), {31'b0, out_valid},
                (c == 3) ? 32'd1 : 32'd0);
        end
        last_result = out_result;
        last_ovf    = out_overflow;
        last_zero   = out_zero;
        last_eq     = out_equal;
        last_ill    = out_illegal;

        dbg_read(rd, d);
        chk("no_early_writeback", d, mregs[rd]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
            chk("stall_no_write",  dbg_data,           mregs[rd]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        if (rd != 5'd0 && !exp_ill) mregs[rd] = exp_result;
        #1;
        out_ready = 1'b0;
        armed     = 1'b0;
        chk("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_hs_in_ready",  {31'b0, in_ready},  32'd1);
        dbg_read(rd, d);
        chk("writeback", d, mregs[rd]);
    endtask

    task automatic sweep(input string name);
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            dbg_read(5'(i), d);
            chk(name, d, mregs[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] d;

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        armed      = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = ALU_ADD;
        in_rs1     = '0;
        in_rs2     = '0;
        in_rd      = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        out_ready  = 1'b0;
        dbg_addr   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid",   {31'b0, out_valid},    32'd0);
        chk("reset_in_ready",    {31'b0, in_ready},     32'd1);
        chk("reset_out_result",  out_result,            32'd0);
        chk("reset_out_rd",      {27'b0, out_rd},       32'd0);
        chk("reset_flags",       {28'b0, out_overflow, out_zero, out_equal, out_illegal},
            32'd0);
        sweep("reset_regfile");

        // Immediate add
        issue(ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 0);
        chk("pin_add_imm", last_result, 32'd5);
        chk("pin_add_zero", {31'b0, last_zero}, 32'd0);
        dbg_read(5'd1, d);
        chk("pin_x1", d, 32'd5);

        // Register subtract
        issue(ALU_SUB, 5'd2, 5'd1, 5'd1, 32'hDEAD_BEEF, 1'b0, 0);
        chk("pin_sub_reg", last_result, 32'd0);
        chk("pin_sub_zero_eq", {30'b0, last_zero, last_eq}, 32'd3);
        issue(ALU_SUB, 5'd3, 5'd0, 5'd0, 32'd7, 1'b1, 0);
        chk("pin_sub_neg", last_result, 32'hFFFF_FFF9);

        // Overflow and signed compare
        issue(ALU_ADD, 5'd4, 5'd0, 5'd0, 32'h7FFF_FFFF, 1'b1, 0);
        issue(ALU_ADD, 5'd5, 5'd4, 5'd0, 32'd1, 1'b1, 0);
        chk("pin_add_ovf_res", last_result, 32'h8000_0000);
        chk("pin_add_ovf", {31'b0, last_ovf}, 32'd1);
        issue(ALU_SLT, 5'd6, 5'd5, 5'd4, 32'd0, 1'b0, 0);
        chk("pin_slt", last_result, 32'd1);
        issue(ALU_SLTU, 5'd10, 5'd5, 5'd4, 32'd0, 1'b0, 0);
        chk("pin_sltu", last_result, 32'd0);

        // x0 and illegal ops
        issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd9, 1'b1, 0);
        chk("pin_x0_result", last_result, 32'd9);
        dbg_read(5'd0, d);
        chk("pin_x0_reads_zero", d, 32'd0);
        issue(alu_control_t'(4'd4), 5'd7, 5'd1, 5'd0, 32'd3, 1'b1, 0);
        chk("pin_illegal", {31'b0, last_ill}, 32'd1);
        chk("pin_illegal_res", last_result, 32'd0);
        dbg_read(5'd7, d);
        chk("pin_x7_unchanged", d, 32'd0);
        issue(alu_control_t'(4'd14), 5'd18, 5'd3, 5'd1, 32'd0, 1'b0, 1);
        chk("pin_illegal14", {31'b0, last_ill}, 32'd1);

        // Backpressure
        issue(ALU_XOR, 5'd11, 5'd5, 5'd3, 32'd0, 1'b0, 10);
        chk("pin_xor", last_result, 32'h7FFF_FFF9);

        // Remaining operations
        issue(ALU_SRA, 5'd12, 5'd3, 5'd0, 32'd4, 1'b1, 2);
        chk("pin_sra", last_result, 32'hFFFF_FFFF);
        issue(ALU_SUB, 5'd13, 5'd5, 5'd0, 32'd1, 1'b1, 0);
        chk("pin_sub_ovf", {31'b0, last_ovf}, 32'd1);
        issue(ALU_SLL, 5'd14, 5'd1, 5'd0, 32'd28, 1'b1, 0);
        chk("pin_sll", last_result, 32'h5000_0000);
        issue(ALU_SRL, 5'd15, 5'd3, 5'd0, 32'd28, 1'b1, 0);
        chk("pin_srl", last_result, 32'h0000_000F);
        issue(ALU_AND, 5'd16, 5'd3, 5'd1, 32'd0, 1'b0, 0);
        chk("pin_and", last_result, 32'd1);
        issue(ALU_OR, 5'd17, 5'd2, 5'd0, 32'd0, 1'b1, 0);
        chk("pin_or_zero", {31'b0, last_zero}, 32'd1);
        sweep("regfile_before_abort");

        // Reset during S_EXEC aborts an ADD to x8
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = ALU_ADD;
        in_rd      = 5'd8;
        in_rs1     = 5'd1;
        in_imm     = 32'd3;
        in_use_imm = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        chk("abort_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("abort_out_result", out_result,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_completion", {31'b0, out_valid}, 32'd0);
            chk("abort_in_ready",      {31'b0, in_ready},  32'd1);
        end
        dbg_read(5'd8, d);
        chk("abort_x8", d, 32'd0);
        sweep("regfile_after_abort");

        issue(ALU_ADD, 5'd9, 5'd0, 5'd0, 32'h11, 1'b1, 0);
        chk("pin_recover", last_result, 32'h11);
        sweep("regfile_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
